// File: rtl/maquina_pkg.sv
// Shared types and defaults for the beverage vending controller.
// Holds the FSM state enum, the default price/recipe tables and the coin decoder.
package maquina_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDispense,
        StFin
    } state_e;

    localparam int unsigned DefNProd  = 5;
    localparam int unsigned DefNIng   = 5;
    localparam int unsigned DefMoneyW = 12;

    // Product p sits at slice p, so the rightmost entry is product 0.
    localparam logic [DefNProd*DefMoneyW-1:0] DefaultPrices =
        {12'd300, 12'd900, 12'd800, 12'd700, 12'd600};
    localparam logic [DefNProd*DefNIng-1:0] DefaultRecipes =
        {5'b00001, 5'b01101, 5'b01111, 5'b00111, 5'b00011};

    localparam int unsigned IngAgua      = 0;
    localparam int unsigned IngCafe      = 1;
    localparam int unsigned IngLeche     = 2;
    localparam int unsigned IngChocolate = 3;
    localparam int unsigned IngAzucar    = 4;

    function automatic int unsigned coin_value(input logic [1:0] code,
                                               input int unsigned c1,
                                               input int unsigned c2,
                                               input int unsigned c3);
        int unsigned val;
        case (code)
            2'b01:   val = c1;
            2'b10:   val = c2;
            2'b11:   val = c3;
            default: val = 0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/secuenciador_ingredientes.sv
// Walks the set bits of a latched recipe in ascending order, holding each
// ingredient output high for STEP_CYCLES cycles; done marks the final cycle.
module secuenciador_ingredientes #(
    parameter int unsigned N_ING       = 5,
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_ING-1:0] recipe,
    output logic [N_ING-1:0] led_ing,
    output logic             done
);

    localparam int unsigned IdxW   = (N_ING > 1) ? $clog2(N_ING) : 1;
    localparam int unsigned DwellW = $clog2(STEP_CYCLES + 1);

    logic             active_q, active_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [N_ING-1:0] recipe_q, recipe_d;

    logic [IdxW-1:0] first_idx, next_idx;
    logic            next_found, last_dwell;

    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        // Descending scans so the lowest qualifying index wins.
        for (int i = N_ING - 1; i >= 0; i--) begin
            if (recipe[i]) begin
                first_idx = IdxW'(i);
            end
            if (recipe_q[i] && (i > int'(idx_q))) begin
                next_idx   = IdxW'(i);
                next_found = 1'b1;
            end
        end
        last_dwell = (dwell_q == DwellW'(STEP_CYCLES - 1));
        done       = active_q && last_dwell && !next_found;
    end

    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        dwell_d  = dwell_q;
        recipe_d = recipe_q;
        if (start) begin
            recipe_d = recipe;
            idx_d    = first_idx;
            dwell_d  = '0;
            active_d = |recipe;
        end else if (active_q) begin
            if (last_dwell) begin
                dwell_d = '0;
                if (next_found) begin
                    idx_d = next_idx;
                end else begin
                    active_d = 1'b0;
                end
            end else begin
                dwell_d = dwell_q + DwellW'(1);
            end
        end
    end

    always_comb begin
        led_ing = active_q ? (N_ING'(1) << idx_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            dwell_q  <= '0;
            recipe_q <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            dwell_q  <= dwell_d;
            recipe_q <= recipe_d;
        end
    end

endmodule

// File: rtl/maquina_bebidas.sv
// Beverage vending controller: coin credit, selection check against the price
// table, ingredient sequencing, change reporting and cancel/timeout refund.
module maquina_bebidas
    import maquina_pkg::*;
#(
    parameter int unsigned N_PROD         = 5,
    parameter int unsigned N_ING          = 5,
    parameter int unsigned MONEY_W        = 12,
    parameter int unsigned COIN1          = 100,
    parameter int unsigned COIN2          = 500,
    parameter int unsigned COIN3          = 1000,
    parameter logic [N_PROD*MONEY_W-1:0] PRICES  = DefaultPrices,
    parameter logic [N_PROD*N_ING-1:0]   RECIPES = DefaultRecipes,
    parameter int unsigned STEP_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                      clk_fpga,
    input  logic                      rst,
    input  logic [1:0]                moneda,
    input  logic                      coin_valid,
    input  logic [$clog2(N_PROD)-1:0] sel,
    input  logic                      sel_valid,
    input  logic                      cancel,
    output logic [N_ING-1:0]          led_ing,
    output logic                      busy,
    output logic                      coin_reject,
    output logic                      sel_error,
    output logic                      enable_fin,
    output logic [MONEY_W-1:0]        ingresado,
    output logic [MONEY_W-1:0]        devuelto
);

    localparam int unsigned SelW   = $clog2(N_PROD);
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [MONEY_W-1:0] ingresado_q, ingresado_d;
    logic [MONEY_W-1:0] devuelto_q, devuelto_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic               coin_reject_q, coin_reject_d;
    logic               sel_error_q, sel_error_d;

    logic [MONEY_W-1:0] coin_val, price, credit_eff;
    logic [MONEY_W:0]   coin_sum;
    logic               coin_present, coin_fits, sel_in_range, any_event;
    logic [SelW-1:0]    sel_idx;
    logic [N_ING-1:0]   recipe_sel;
    logic               seq_start, seq_done;

    always_comb begin
        coin_val     = MONEY_W'(coin_value(moneda, COIN1, COIN2, COIN3));
        coin_present = coin_valid && (moneda != 2'b00);
        coin_sum     = {1'b0, credit_q} + {1'b0, coin_val};
        coin_fits    = !coin_sum[MONEY_W];
        sel_in_range = 32'(sel) < N_PROD;
        sel_idx      = sel_in_range ? sel : '0;
        price        = PRICES[32'(sel_idx)*MONEY_W +: MONEY_W];
        recipe_sel   = RECIPES[32'(sel_idx)*N_ING +: N_ING];
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        ingresado_d   = ingresado_q;
        devuelto_d    = devuelto_q;
        timer_d       = timer_q;
        coin_reject_d = 1'b0;
        sel_error_d   = 1'b0;
        seq_start     = 1'b0;
        credit_eff    = credit_q;
        any_event     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (coin_present) begin
                    credit_d    = coin_val;
                    ingresado_d = coin_val;
                    devuelto_d  = '0;
                    timer_d     = '0;
                    state_d     = StCollect;
                end
            end
            StCollect: begin
                // A coin in the same cycle counts before cancel/sel are judged.
                if (coin_present) begin
                    if (coin_fits) begin
                        credit_eff  = coin_sum[MONEY_W-1:0];
                        ingresado_d = credit_eff;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                credit_d  = credit_eff;
                any_event = (coin_present && coin_fits) || sel_valid || cancel;
                if (cancel) begin
                    devuelto_d = credit_eff;
                    credit_d   = '0;
                    state_d    = StFin;
                end else if (sel_valid) begin
                    if (!sel_in_range || (credit_eff < price)) begin
                        sel_error_d = 1'b1;
                    end else begin
                        devuelto_d = credit_eff - price;
                        credit_d   = '0;
                        seq_start  = |recipe_sel;
                        state_d    = (|recipe_sel) ? StDispense : StFin;
                    end
                end
                if (any_event) begin
                    timer_d = '0;
                end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                    devuelto_d = credit_q;
                    credit_d   = '0;
                    state_d    = StFin;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StDispense: begin
                coin_reject_d = coin_present;
                sel_error_d   = sel_valid;
                if (seq_done) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                coin_reject_d = coin_present;
                sel_error_d   = sel_valid;
                credit_d      = '0;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q == StDispense) || (state_q == StFin);
        enable_fin  = (state_q == StFin);
        coin_reject = coin_reject_q;
        sel_error   = sel_error_q;
        ingresado   = ingresado_q;
        devuelto    = devuelto_q;
    end

    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            ingresado_q   <= '0;
            devuelto_q    <= '0;
            timer_q       <= '0;
            coin_reject_q <= 1'b0;
            sel_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            ingresado_q   <= ingresado_d;
            devuelto_q    <= devuelto_d;
            timer_q       <= timer_d;
            coin_reject_q <= coin_reject_d;
            sel_error_q   <= sel_error_d;
        end
    end

    secuenciador_ingredientes #(
        .N_ING       (N_ING),
        .STEP_CYCLES (STEP_CYCLES)
    ) u_secuenciador (
        .clk     (clk_fpga),
        .rst     (rst),
        .start   (seq_start),
        .recipe  (recipe_sel),
        .led_ing (led_ing),
        .done    (seq_done)
    );

endmodule

// File: tb/tb_maquina_bebidas.sv
// Directed bench for maquina_bebidas with default parameters; each task drives
// one scenario and compares outputs against hand-computed values.
module tb_maquina_bebidas;

    logic        clk_fpga = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  moneda = 2'b00;
    logic        coin_valid = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        sel_valid = 1'b0;
    logic        cancel = 1'b0;
    logic [4:0]  led_ing;
    logic        busy, coin_reject, sel_error, enable_fin;
    logic [11:0] ingresado, devuelto;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk_fpga = ~clk_fpga;

    maquina_bebidas dut (
        .clk_fpga    (clk_fpga),
        .rst         (rst),
        .moneda      (moneda),
        .coin_valid  (coin_valid),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .cancel      (cancel),
        .led_ing     (led_ing),
        .busy        (busy),
        .coin_reject (coin_reject),
        .sel_error   (sel_error),
        .enable_fin  (enable_fin),
        .ingresado   (ingresado),
        .devuelto    (devuelto)
    );

    task automatic tick();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] code);
        moneda = code;
        coin_valid = 1'b1;
        tick();
        coin_valid = 1'b0;
        moneda = 2'b00;
    endtask

    task automatic do_sel(input logic [2:0] s);
        sel = s;
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({led_ing, busy, coin_reject, sel_error, enable_fin} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0", {led_ing, busy, coin_reject, sel_error,
                                                         enable_fin});
        end
        n_cmp++;
        if ({ingresado, devuelto} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_money: got %0d/%0d want 0/0", ingresado, devuelto);
        end
    endtask

    task automatic test_compra_basica();
        logic [4:0] exp_led;
        put_coin(2'b01);
        put_coin(2'b01);
        put_coin(2'b01);
        put_coin(2'b10);
        n_cmp++;
        if (ingresado !== 12'd800) begin
            n_fail++;
            $display("FAIL basic_credit: got %0d want 800", ingresado);
        end
        do_sel(3'd0);
        n_cmp++;
        if (devuelto !== 12'd200) begin
            n_fail++;
            $display("FAIL basic_change: got %0d want 200", devuelto);
        end
        for (int c = 0; c < 8; c++) begin
            exp_led = (c < 4) ? 5'b00001 : 5'b00010;
            n_cmp++;
            if ({led_ing, enable_fin, busy} !== {exp_led, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL basic_led c%0d: got %b want %b", c, {led_ing, enable_fin, busy},
                         {exp_led, 2'b01});
            end
            tick();
        end
        n_cmp++;
        if ({enable_fin, led_ing, ingresado} !== {1'b1, 5'b0, 12'd800}) begin
            n_fail++;
            $display("FAIL basic_fin: got fin=%b led=%b ing=%0d want 1/00000/800",
                     enable_fin, led_ing, ingresado);
        end
        tick();
        n_cmp++;
        if ({enable_fin, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_idle: got %b want 00", {enable_fin, busy});
        end
    endtask

    task automatic test_sel_error();
        logic [4:0] exp_led;
        put_coin(2'b10);
        n_cmp++;
        if (devuelto !== 12'd0) begin
            n_fail++;
            $display("FAIL devuelto_cleared: got %0d want 0", devuelto);
        end
        do_sel(3'd2);
        n_cmp++;
        if ({sel_error, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL selerr_short: got %b want 10", {sel_error, busy});
        end
        put_coin(2'b10);
        n_cmp++;
        if ({ingresado, sel_error} !== {12'd1000, 1'b0}) begin
            n_fail++;
            $display("FAIL selerr_topup: got %0d/%b want 1000/0", ingresado, sel_error);
        end
        do_sel(3'd2);
        n_cmp++;
        if (devuelto !== 12'd200) begin
            n_fail++;
            $display("FAIL selerr_change: got %0d want 200", devuelto);
        end
        for (int c = 0; c < 16; c++) begin
            exp_led = 5'b00001 << (c / 4);
            n_cmp++;
            if (led_ing !== exp_led) begin
                n_fail++;
                $display("FAIL p2_led c%0d: got %b want %b", c, led_ing, exp_led);
            end
            tick();
        end
        n_cmp++;
        if (enable_fin !== 1'b1) begin
            n_fail++;
            $display("FAIL p2_fin: got %b want 1", enable_fin);
        end
        tick();
    endtask

    task automatic test_overflow_cancel();
        for (int k = 0; k < 4; k++) put_coin(2'b11);
        n_cmp++;
        if (ingresado !== 12'd4000) begin
            n_fail++;
            $display("FAIL ovf_credit: got %0d want 4000", ingresado);
        end
        put_coin(2'b11);
        n_cmp++;
        if ({coin_reject, ingresado} !== {1'b1, 12'd4000}) begin
            n_fail++;
            $display("FAIL ovf_reject: got %b/%0d want 1/4000", coin_reject, ingresado);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_cmp++;
        if ({coin_reject, enable_fin, led_ing, devuelto} !== {2'b01, 5'b0, 12'd4000}) begin
            n_fail++;
            $display("FAIL cancel_refund: got rej=%b fin=%b led=%b dev=%0d want 0/1/0/4000",
                     coin_reject, enable_fin, led_ing, devuelto);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        put_coin(2'b10);
        n = 0;
        while (!enable_fin && n < 1100) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n !== 1000) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d want 1000", n);
        end
        n_cmp++;
        if (devuelto !== 12'd500) begin
            n_fail++;
            $display("FAIL timeout_refund: got %0d want 500", devuelto);
        end
        tick();
    endtask

    task automatic test_coin_in_dispense();
        put_coin(2'b10);
        put_coin(2'b10);
        do_sel(3'd4);
        put_coin(2'b10);
        n_cmp++;
        if ({coin_reject, led_ing, ingresado, devuelto} !== {1'b1, 5'b00001, 12'd1000, 12'd700})
        begin
            n_fail++;
            $display("FAIL disp_coin: got rej=%b led=%b ing=%0d dev=%0d want 1/00001/1000/700",
                     coin_reject, led_ing, ingresado, devuelto);
        end
        do_sel(3'd0);
        n_cmp++;
        if ({sel_error, led_ing} !== {1'b1, 5'b00001}) begin
            n_fail++;
            $display("FAIL disp_sel: got %b want 100001", {sel_error, led_ing});
        end
        tick();
        tick();
        n_cmp++;
        if ({enable_fin, devuelto} !== {1'b1, 12'd700}) begin
            n_fail++;
            $display("FAIL disp_fin: got %b/%0d want 1/700", enable_fin, devuelto);
        end
        tick();
    endtask

    task automatic test_coin_sel_same_cycle();
        put_coin(2'b01);
        put_coin(2'b01);
        moneda = 2'b01;
        coin_valid = 1'b1;
        sel = 3'd4;
        sel_valid = 1'b1;
        tick();
        moneda = 2'b00;
        coin_valid = 1'b0;
        sel_valid = 1'b0;
        n_cmp++;
        if ({devuelto, ingresado, led_ing, coin_reject, sel_error} !==
            {12'd0, 12'd300, 5'b00001, 2'b00}) begin
            n_fail++;
            $display("FAIL same_cycle: got dev=%0d ing=%0d led=%b rej=%b err=%b want 0/300/00001/0/0",
                     devuelto, ingresado, led_ing, coin_reject, sel_error);
        end
        for (int k = 0; k < 4; k++) tick();
        n_cmp++;
        if (enable_fin !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_fin: got %b want 1", enable_fin);
        end
        tick();
    endtask

    task automatic test_sel_out_of_range();
        put_coin(2'b01);
        do_sel(3'd5);
        n_cmp++;
        if ({sel_error, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL sel_range: got %b want 10", {sel_error, busy});
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_cmp++;
        if ({enable_fin, devuelto} !== {1'b1, 12'd100}) begin
            n_fail++;
            $display("FAIL range_cancel: got %b/%0d want 1/100", enable_fin, devuelto);
        end
        tick();
    endtask

    task automatic test_reset_mid_dispense();
        logic saw_fin;
        put_coin(2'b11);
        do_sel(3'd1);
        tick();
        tick();
        n_cmp++;
        if ({led_ing, devuelto} !== {5'b00001, 12'd300}) begin
            n_fail++;
            $display("FAIL rst_pre: got %b/%0d want 00001/300", led_ing, devuelto);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({led_ing, busy, enable_fin, coin_reject, sel_error, ingresado, devuelto} !== 33'd0)
        begin
            n_fail++;
            $display("FAIL rst_mid: got led=%b busy=%b fin=%b ing=%0d dev=%0d want all 0",
                     led_ing, busy, enable_fin, ingresado, devuelto);
        end
        saw_fin = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            saw_fin = saw_fin | enable_fin | busy;
        end
        n_cmp++;
        if (saw_fin !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_fin: got %b want 0", saw_fin);
        end
    endtask

    initial begin
        test_reset();
        test_compra_basica();
        test_sel_error();
        test_overflow_cancel();
        test_timeout();
        test_coin_in_dispense();
        test_coin_sel_same_cycle();
        test_sel_out_of_range();
        test_reset_mid_dispense();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
